// File: rtl/phase_lock_pkg.sv
// Shared types and helpers for the phase lock controller.
// FSM state and update-direction encodings, plus the delay-code reset midpoint.
package phase_lock_pkg;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        REF_FIRST = 2'd1,
        FB_FIRST  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TIE = 2'd0,
        UP  = 2'd1,
        DN  = 2'd2
    } dir_t;

    // Midpoint of a code_w-bit delay code: 2^(code_w-1).
    function automatic int unsigned code_mid(input int unsigned code_w);
        return 32'd1 << (code_w - 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
// Latency from a din rising transition to the rise pulse is SYNC_STAGES+1 cycles.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            last_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/phase_lock_ctrl.sv
// Bang-bang phase lock controller: steers a saturating delay code from DIV_M/DIV_N edge order.
// Optional comparison timeout is compiled in with the PLC_TIMEOUT_EN macro.
module phase_lock_ctrl
    import phase_lock_pkg::*;
#(
    parameter int CODE_W      = 6,
    parameter int LOCK_CNT    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk_out,
    input  logic              rst_n,
    input  logic              en,
    input  logic              DIV_M,
    input  logic              DIV_N,
    output logic [CODE_W-1:0] code,
    output logic              up,
    output logic              dn,
    output logic              lock,
    output logic              timeout
);

    localparam logic [CODE_W-1:0] CODE_RST = CODE_W'(code_mid(CODE_W));
    localparam logic [CODE_W-1:0] CODE_MAX = '1;
    localparam int                CNT_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(LOCK_CNT);

    logic   ref_e;
    logic   fb_e;
    state_t state;
    state_t state_nx;
    dir_t   dir_q;
    dir_t   dir_nx;
    dir_t   last_dir;
    logic   tmo_fire;

    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             is_upd;
    logic             opposite;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ref (
        .clk   (clk_out),
        .rst_n (rst_n),
        .din   (DIV_M),
        .rise  (ref_e)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fb (
        .clk   (clk_out),
        .rst_n (rst_n),
        .din   (DIV_N),
        .rise  (fb_e)
    );

`ifdef PLC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             tmo_restart;
    logic             waiting;

    assign waiting     = (state == REF_FIRST) || (state == FB_FIRST);
    assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    // Entering a wait state, or a repeated first edge, restarts the count.
    assign tmo_restart = en && ((state == ARMED && (state_nx == REF_FIRST || state_nx == FB_FIRST)) ||
                                (state == REF_FIRST && state_nx == REF_FIRST && ref_e) ||
                                (state == FB_FIRST  && state_nx == FB_FIRST  && fb_e));
    assign tmo_fire    = en && waiting && (state_nx == ARMED);

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (tmo_restart) begin
            tmo_cnt <= TMO_W'(1);
        end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARMED;
            dir_q <= TIE;
        end else begin
            state <= state_nx;
            dir_q <= dir_nx;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nx = state;
        dir_nx   = dir_q;
        if (!en) begin
            state_nx = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    if (ref_e && fb_e) begin
                        state_nx = UPDATE;
                        dir_nx   = TIE;
                    end else if (ref_e) begin
                        state_nx = REF_FIRST;
                    end else if (fb_e) begin
                        state_nx = FB_FIRST;
                    end
                end
                REF_FIRST: begin
                    if (fb_e) begin
                        state_nx = UPDATE;
                        dir_nx   = DN;
                    end
`ifdef PLC_TIMEOUT_EN
                    else if (!ref_e && tmo_hit) begin
                        state_nx = ARMED;
                    end
`endif
                end
                FB_FIRST: begin
                    if (ref_e) begin
                        state_nx = UPDATE;
                        dir_nx   = UP;
                    end
`ifdef PLC_TIMEOUT_EN
                    else if (!fb_e && tmo_hit) begin
                        state_nx = ARMED;
                    end
`endif
                end
                UPDATE:  state_nx = ARMED;
                default: state_nx = ARMED;
            endcase
        end
    end

    assign is_upd   = (state == UPDATE) && en;
    // A reversal only counts once a real direction has been seen since reset.
    assign opposite = (last_dir != TIE) && (dir_q != last_dir);
    assign cnt_inc  = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            code     <= CODE_RST;
            up       <= 1'b0;
            dn       <= 1'b0;
            lock     <= 1'b0;
            timeout  <= 1'b0;
            lock_cnt <= '0;
            last_dir <= TIE;
        end else begin
            up      <= 1'b0;
            dn      <= 1'b0;
            timeout <= tmo_fire;
            lock    <= (lock_cnt == CNT_MAX);
            if (tmo_fire) begin
                lock_cnt <= '0;
            end else if (is_upd) begin
                case (dir_q)
                    UP: begin
                        last_dir <= UP;
                        if (code == CODE_MAX) begin
                            lock_cnt <= '0;
                        end else begin
                            code     <= code + 1'b1;
                            up       <= 1'b1;
                            lock_cnt <= opposite ? cnt_inc : '0;
                        end
                    end
                    DN: begin
                        last_dir <= DN;
                        if (code == '0) begin
                            lock_cnt <= '0;
                        end else begin
                            code     <= code - 1'b1;
                            dn       <= 1'b1;
                            lock_cnt <= opposite ? cnt_inc : '0;
                        end
                    end
                    default: lock_cnt <= cnt_inc;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_lock_ctrl.sv
// Scoreboard bench for phase_lock_ctrl: a reference model queues expected code steps
// per divided period; a monitor pops them as up/dn pulses appear.
module tb_phase_lock_ctrl;
    import phase_lock_pkg::*;

    localparam int CODE_W   = 6;
    localparam int LOCK_CNT = 8;
    localparam int CODE_TOP = (1 << CODE_W) - 1;

    typedef struct {
        logic [CODE_W-1:0] code;
        logic [1:0]        ud;
    } exp_t;

    logic              clk_out = 1'b0;
    logic              rst_n   = 1'b0;
    logic              en      = 1'b1;
    logic              DIV_M   = 1'b0;
    logic              DIV_N   = 1'b0;
    logic [CODE_W-1:0] code;
    logic              up;
    logic              dn;
    logic              lock;
    logic              timeout;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   tmo_seen = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    int   m_code;
    int   m_cnt;
    dir_t m_last;

    phase_lock_ctrl #(
        .CODE_W      (CODE_W),
        .LOCK_CNT    (LOCK_CNT),
        .SYNC_STAGES (2),
        .TIMEOUT     (64)
    ) dut (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .en      (en),
        .DIV_M   (DIV_M),
        .DIV_N   (DIV_N),
        .code    (code),
        .up      (up),
        .dn      (dn),
        .lock    (lock),
        .timeout (timeout)
    );

    always #5 clk_out = ~clk_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: every up/dn pulse must match the oldest queued expectation.
    always @(negedge clk_out) begin
        if (rst_n) begin
            if (up || dn) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_pulse", 32'({up, dn}), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_code", 32'(code), 32'(mon_e.code));
                    check("sb_updn", 32'({up, dn}), 32'(mon_e.ud));
                end
            end
            if (timeout) tmo_seen++;
        end
    end

    task automatic model_step(input dir_t d);
        bit sat;
        bit opp;
        if (d == TIE) begin
            if (m_cnt < LOCK_CNT) m_cnt++;
        end else begin
            sat = (d == UP && m_code == CODE_TOP) || (d == DN && m_code == 0);
            opp = (m_last != TIE) && (m_last != d);
            if (sat) begin
                m_cnt = 0;
            end else begin
                m_code += (d == UP) ? 1 : -1;
                sb_q.push_back('{code: CODE_W'(m_code), ud: (d == UP) ? 2'b10 : 2'b01});
                m_cnt = opp ? ((m_cnt < LOCK_CNT) ? m_cnt + 1 : m_cnt) : 0;
            end
            m_last = d;
        end
    endtask

    // One 16-cycle divided period. lead>0: DIV_N leads by lead; lead<0: DIV_M leads.
    task automatic run_period(input int lead);
        int tm;
        int tn;
        dir_t d;
        tm = (lead > 0) ? lead : 0;
        tn = (lead < 0) ? -lead : 0;
        d  = (lead > 0) ? UP : (lead < 0) ? DN : TIE;
        if (en) model_step(d);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_out);
            DIV_M = (i >= tm) && (i < tm + 8);
            DIV_N = (i >= tn) && (i < tn + 8);
        end
        check("period_code", 32'(code), 32'(m_code));
        check("period_lock", 32'(lock), 32'(m_cnt == LOCK_CNT));
    endtask

    task automatic do_reset();
        @(negedge clk_out);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        rst_n = 1'b0;
        DIV_M = 1'b0;
        DIV_N = 1'b0;
        #1;
        check("rst_code", 32'(code), 32'(1 << (CODE_W - 1)));
        check("rst_outs", 32'({up, dn, lock, timeout}), 32'd0);
        sb_q.delete();
        m_code   = 1 << (CODE_W - 1);
        m_cnt    = 0;
        m_last   = TIE;
        tmo_seen = 0;
        repeat (3) @(negedge clk_out);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_out);
    endtask

    initial begin
        int tmo_at;

        do_reset();

        // Coincident edges: code holds, lock after the 8th TIE update.
        for (int p = 0; p < 10; p++) run_period(0);

        // en low: a leading feedback must not move code or drop lock.
        en = 1'b0;
        for (int p = 0; p < 3; p++) run_period(3);
        en = 1'b1;

        // Alternating lead/lag: 1 + 8 reversals lock, then same-direction steps unlock.
        do_reset();
        for (int p = 0; p < 9; p++) run_period((p % 2 == 0) ? 2 : -2);
        run_period(2);
        run_period(2);

        // Feedback leads: climb to all-ones and hold.
        do_reset();
        for (int p = 0; p < 33; p++) run_period(3);

        // Reference leads: mid-run reset from 63, then descend to 0 and hold.
        do_reset();
        for (int p = 0; p < 34; p++) run_period(-3);

        // Timeout: DIV_M repeats (restarting the wait), then stops with DIV_N held low.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk_out);
                DIV_M = (i < 8);
            end
        end
        check("tmo_none_while_repeating", 32'(tmo_seen), 32'd0);
        @(negedge clk_out);
        DIV_M  = 1'b1;
        tmo_at = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk_out);
            if (i == 8) DIV_M = 1'b0;
            if (timeout && tmo_at < 0) tmo_at = i;
        end
`ifdef PLC_TIMEOUT_EN
        check("tmo_cycle", 32'(tmo_at), 32'd67);
        check("tmo_count", 32'(tmo_seen), 32'd1);
`else
        check("tmo_cycle", 32'(tmo_at), 32'hFFFF_FFFF);
        check("tmo_count", 32'(tmo_seen), 32'd0);
        // Still waiting in REF_FIRST, so a late feedback edge completes a DN update.
        model_step(DN);
`endif
        check("tmo_code", 32'(code), 32'(1 << (CODE_W - 1)));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_out);
            DIV_N = (i < 8);
        end
        check("post_tmo_code", 32'(code), 32'(m_code));
`ifdef PLC_TIMEOUT_EN
        check("post_tmo_count", 32'(tmo_seen), 32'd1);
`else
        check("post_tmo_count", 32'(tmo_seen), 32'd0);
`endif

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
